// File: rtl/miriscv_arb_pkg.sv
// Shared types and constants for the miriscv instruction/data RAM arbiter.
package miriscv_arb_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_e;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // An all-zero word decodes as an illegal instruction in the core.
  localparam logic [WORD_W-1:0] INSTR_ILLEGAL = 32'h0;

endpackage

// File: rtl/miriscv_rr_arb2.sv
// Two-way request picker for the miriscv RAM arbiter.
// Bit 0 of req_i/gnt_o is the fetch port, bit 1 the load/store port.
// Default build: round-robin on conflict, the port not granted last wins.
// Define MIRISCV_ARB_DATA_PRIO_EN for fixed priority: data always wins a conflict.
module miriscv_rr_arb2
  import miriscv_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_port_e  last_grant_i,
  output logic [1:0] gnt_o
);

  // Resolve the request pair to a one-hot (or empty) grant.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11: begin
`ifdef MIRISCV_ARB_DATA_PRIO_EN
        gnt_o = 2'b10;
`else
        gnt_o = (last_grant_i == PORT_DATA) ? 2'b01 : 2'b10;
`endif
      end
      default: gnt_o = 2'b00;
    endcase
  end

`ifdef MIRISCV_ARB_DATA_PRIO_EN
  // Fixed priority ignores the grant history.
  arb_port_e last_grant_unused;
  assign last_grant_unused = last_grant_i;
`endif

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares the single-port instruction/data RAM between the core's fetch port
// and its load/store port. One access is granted per cycle; its response is
// returned on the owning port one cycle later. Out-of-range accesses are
// granted without touching the RAM and answer with zero data (plus an error
// flag on the data port).
// Define MIRISCV_ARB_DATA_PRIO_EN to give the data port fixed priority.
module miriscv_mem_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter  int RAM_SIZE = 512,
  localparam int AW       = $clog2(RAM_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              instr_req_i,
  input  logic [WORD_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [WORD_W-1:0] instr_rdata_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [WORD_W-1:0] data_addr_i,
  input  logic [WORD_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [WORD_W-1:0] data_rdata_o,
  output logic              data_err_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(RAM_SIZE * 4);

  logic [1:0]        gnt;
  logic              any_gnt;
  logic [WORD_W-1:0] sel_addr;
  logic              sel_oor;
  logic [1:0]        addr_lsb_unused;

  arb_port_e         last_grant_q, last_grant_d;

  logic              rsp_valid_q;
  arb_port_e         rsp_owner_q;
  logic              rsp_we_q;
  logic              rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata;

  logic [WORD_W-1:0] instr_rdata_q;
  logic [WORD_W-1:0] data_rdata_q;

  miriscv_rr_arb2 u_rr_arb2 (
    .req_i        ({data_req_i, instr_req_i}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];
  assign any_gnt     = |gnt;

  // Address of whichever port owns the grant; the byte offset is irrelevant
  // because every RAM access is a full word.
  assign sel_addr        = gnt[1] ? data_addr_i : instr_addr_i;
  assign sel_oor         = (sel_addr >= ADDR_LIMIT);
  assign addr_lsb_unused = sel_addr[1:0];

  // Drive the RAM from the granted port; fetches are always full-word reads.
  always_comb begin
    mem_req_o   = any_gnt & ~sel_oor;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_addr_o  = sel_addr[AW+1:2];
    mem_wdata_o = '0;
    if (gnt[1]) begin
      mem_we_o    = data_we_i & ~sel_oor;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Remember who was granted last; idle cycles leave the history alone.
  always_comb begin
    last_grant_d = last_grant_q;
    if (any_gnt) begin
      last_grant_d = gnt[1] ? PORT_DATA : PORT_INSTR;
    end
  end

  // Grant history and the one-deep response pipeline.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= PORT_DATA;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= PORT_INSTR;
      rsp_we_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= any_gnt;
      if (any_gnt) begin
        rsp_owner_q <= gnt[1] ? PORT_DATA : PORT_INSTR;
        rsp_we_q    <= gnt[1] & data_we_i;
        rsp_err_q   <= sel_oor;
      end
    end
  end

  // Response data: RAM word for in-range reads, zero for stores and for
  // out-of-range accesses (a zero fetch is an illegal instruction).
  always_comb begin
    rsp_rdata = mem_rdata_i;
    if (rsp_err_q) begin
      rsp_rdata = (rsp_owner_q == PORT_INSTR) ? INSTR_ILLEGAL : '0;
    end else if (rsp_we_q) begin
      rsp_rdata = '0;
    end
  end

  assign instr_rvalid_o = rsp_valid_q & (rsp_owner_q == PORT_INSTR);
  assign data_rvalid_o  = rsp_valid_q & (rsp_owner_q == PORT_DATA);
  assign data_err_o     = data_rvalid_o & rsp_err_q;

  // Each port shows fresh data on its response cycle and otherwise keeps the
  // last word it was given.
  assign instr_rdata_o = instr_rvalid_o ? rsp_rdata : instr_rdata_q;
  assign data_rdata_o  = data_rvalid_o  ? rsp_rdata : data_rdata_q;

  // Capture each port's delivered word so it holds between responses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: these are plain output-holding registers, not a storage array,
      // so resetting them is cheap and makes the rdata outputs reset to zero.
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      if (instr_rvalid_o) instr_rdata_q <= rsp_rdata;
      if (data_rvalid_o)  data_rdata_q  <= rsp_rdata;
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Self-checking bench for miriscv_mem_arbiter: directed scenarios plus a
// randomized traffic run, all checked against a transaction-level model
// (expected grant per cycle, expected response one cycle later, and a shadow
// copy of the RAM contents). Honours MIRISCV_ARB_DATA_PRIO_EN.
module tb_miriscv_mem_arbiter;

  localparam int RAM_SIZE = 512;
  localparam int AW       = $clog2(RAM_SIZE);

  logic          clk;
  logic          rst_n;
  logic          instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0]   instr_addr_i, instr_rdata_o;
  logic          data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i, data_wdata_i, data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  miriscv_mem_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial RAM image; word 0x40 (byte 0x100) starts at zero.
  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'h0;
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  // Synchronous single-port RAM attached to the arbiter.
  logic [31:0] ram [RAM_SIZE];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= ram[mem_addr_o];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [RAM_SIZE];
  bit          ref_last_data;
  bit          exp_valid, exp_is_data, exp_err;
  logic [31:0] exp_rdata, exp_instr_hold, exp_data_hold;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the most recent run_cycle, used by directed tests.
  bit          obs_ig, obs_dg, obs_mem_req, obs_d_rvalid, obs_d_err;
  logic [31:0] obs_d_rdata;

  task automatic model_reset();
    ref_last_data  = 1'b1;
    exp_valid      = 1'b0;
    exp_is_data    = 1'b0;
    exp_err        = 1'b0;
    exp_rdata      = '0;
    exp_instr_hold = '0;
    exp_data_hold  = '0;
  endtask

  task automatic drive_idle();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
  endtask

  // One bus cycle: drive requests, check this cycle's grant and RAM drive,
  // check the response due from the previous grant, then advance the model.
  task automatic run_cycle(input bit ireq, input logic [31:0] iaddr,
                           input bit dreq, input bit dwe, input logic [3:0] dbe,
                           input logic [31:0] daddr, input logic [31:0] dwdata);
    bit          g_i, g_d, oor, want_mem;
    logic [31:0] a;
    int          idx;
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
    @(negedge clk);
    g_i = 1'b0;
    g_d = 1'b0;
    if (ireq && dreq) begin
`ifdef MIRISCV_ARB_DATA_PRIO_EN
      g_d = 1'b1;
`else
      if (ref_last_data) g_i = 1'b1;
      else               g_d = 1'b1;
`endif
    end else begin
      g_i = ireq;
      g_d = dreq;
    end
    a        = g_d ? daddr : iaddr;
    oor      = (a >= 32'(RAM_SIZE * 4));
    want_mem = (g_i || g_d) && !oor;
    idx      = int'(a[AW+1:2]);

    n_cmp++;
    if ({instr_gnt_o, data_gnt_o} !== {g_i, g_d}) begin
      n_bad++;
      $display("FAIL gnt t=%0t: got i=%b d=%b, want i=%b d=%b", $time, instr_gnt_o, data_gnt_o, g_i, g_d);
    end
    n_cmp++;
    if (mem_req_o !== want_mem) begin
      n_bad++;
      $display("FAIL mem_req t=%0t: got %b, want %b", $time, mem_req_o, want_mem);
    end
    if (want_mem) begin
      n_cmp++;
      if ({mem_addr_o, mem_we_o, mem_be_o} !== {a[AW+1:2], g_d & dwe, g_d ? dbe : 4'hF}) begin
        n_bad++;
        $display("FAIL mem_drive t=%0t: got addr=%h we=%b be=%h, want addr=%h we=%b be=%h",
                 $time, mem_addr_o, mem_we_o, mem_be_o, a[AW+1:2], g_d & dwe, g_d ? dbe : 4'hF);
      end
      if (g_d && dwe) begin
        n_cmp++;
        if (mem_wdata_o !== dwdata) begin
          n_bad++;
          $display("FAIL mem_wdata t=%0t: got %h, want %h", $time, mem_wdata_o, dwdata);
        end
      end
    end

    if (exp_valid && !exp_is_data) exp_instr_hold = exp_rdata;
    if (exp_valid &&  exp_is_data) exp_data_hold  = exp_rdata;
    n_cmp++;
    if ({instr_rvalid_o, data_rvalid_o, data_err_o} !==
        {exp_valid & ~exp_is_data, exp_valid & exp_is_data, exp_valid & exp_is_data & exp_err}) begin
      n_bad++;
      $display("FAIL rsp_flags t=%0t: got irv=%b drv=%b err=%b, want irv=%b drv=%b err=%b",
               $time, instr_rvalid_o, data_rvalid_o, data_err_o,
               exp_valid & ~exp_is_data, exp_valid & exp_is_data, exp_valid & exp_is_data & exp_err);
    end
    n_cmp++;
    if (instr_rdata_o !== exp_instr_hold) begin
      n_bad++;
      $display("FAIL instr_rdata t=%0t: got %h, want %h", $time, instr_rdata_o, exp_instr_hold);
    end
    n_cmp++;
    if (data_rdata_o !== exp_data_hold) begin
      n_bad++;
      $display("FAIL data_rdata t=%0t: got %h, want %h", $time, data_rdata_o, exp_data_hold);
    end

    obs_ig       = instr_gnt_o;
    obs_dg       = data_gnt_o;
    obs_mem_req  = mem_req_o;
    obs_d_rvalid = data_rvalid_o;
    obs_d_err    = data_err_o;
    obs_d_rdata  = data_rdata_o;

    exp_valid   = g_i || g_d;
    exp_is_data = g_d;
    exp_err     = oor;
    if (oor)              exp_rdata = '0;
    else if (g_d && dwe)  exp_rdata = '0;
    else                  exp_rdata = ref_mem[idx];
    if (g_d && dwe && !oor)
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[idx][8*b +: 8] = dwdata[8*b +: 8];
    if (g_i || g_d) ref_last_data = g_d;

    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({instr_rvalid_o, data_rvalid_o, data_err_o, instr_gnt_o, data_gnt_o, mem_req_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL %s_flags: got irv=%b drv=%b err=%b ig=%b dg=%b mreq=%b, want all 0", tag,
               instr_rvalid_o, data_rvalid_o, data_err_o, instr_gnt_o, data_gnt_o, mem_req_o);
    end
    n_cmp++;
    if ({instr_rdata_o, data_rdata_o} !== 64'h0) begin
      n_bad++;
      $display("FAIL %s_rdata: got i=%h d=%h, want 0", tag, instr_rdata_o, data_rdata_o);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_instr_stream();
    bit [2:0] g;
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1, 32'(4 * k), 1'b0, 1'b0, '0, '0, '0);
      g[k] = obs_ig;
    end
    idle_cycle();
    n_cmp++;
    if (g !== 3'b111) begin
      n_bad++;
      $display("FAIL instr_stream_gnt: got %b, want 111", g);
    end
    n_cmp++;
    if (instr_rdata_o !== init_word(2)) begin
      n_bad++;
      $display("FAIL instr_stream_last: got %h, want %h", instr_rdata_o, init_word(2));
    end
  endtask

  task automatic test_store_load();
    run_cycle(1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    run_cycle(1'b0, '0, 1'b1, 1'b0, 4'hF,    32'h100, '0);
    n_cmp++;
    if ({obs_d_rvalid, obs_d_rdata} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL store_ack: got rvalid=%b rdata=%h, want 1 00000000", obs_d_rvalid, obs_d_rdata);
    end
    idle_cycle();
    n_cmp++;
    if (data_rdata_o !== 32'h0000_BEEF) begin
      n_bad++;
      $display("FAIL load_after_store: got %h, want 0000beef", data_rdata_o);
    end
  endtask

  task automatic test_conflict();
    bit [5:0] seq_i, seq_d;
    test_reset();
    for (int k = 0; k < 6; k++) begin
      run_cycle(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, '0);
      seq_i = {seq_i[4:0], obs_ig};
      seq_d = {seq_d[4:0], obs_dg};
    end
    idle_cycle();
    n_cmp++;
`ifdef MIRISCV_ARB_DATA_PRIO_EN
    if ({seq_i, seq_d} !== 12'b000000_111111) begin
`else
    if ({seq_i, seq_d} !== 12'b101010_010101) begin
`endif
      n_bad++;
      $display("FAIL conflict_seq: got i=%b d=%b", seq_i, seq_d);
    end
  endtask

  task automatic test_out_of_range();
    bit m;
    run_cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h800, '0);
    m = obs_mem_req;
    idle_cycle();
    n_cmp++;
    if ({m, obs_d_rvalid, obs_d_err, obs_d_rdata} !== {3'b011, 32'h0}) begin
      n_bad++;
      $display("FAIL out_of_range: got mreq=%b rvalid=%b err=%b rdata=%h, want 0 1 1 0",
               m, obs_d_rvalid, obs_d_err, obs_d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    run_cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h40, '0);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_cycle(1'b1, 32'h8, 1'b1, 1'b0, 4'hF, 32'h4, '0);
    n_cmp++;
`ifdef MIRISCV_ARB_DATA_PRIO_EN
    if ({obs_ig, obs_dg} !== 2'b01) begin
`else
    if ({obs_ig, obs_dg} !== 2'b10) begin
`endif
      n_bad++;
      $display("FAIL post_reset_conflict: got i=%b d=%b", obs_ig, obs_dg);
    end
    idle_cycle();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return 32'h800 + ($urandom & 32'h000F_FFFF);
    return (32'($urandom_range(0, RAM_SIZE - 1)) << 2) | ($urandom & 32'h3);
  endfunction

  task automatic test_random();
    bit          pi_req, pd_req, pd_we;
    logic [31:0] pi_addr, pd_addr, pd_wdata;
    logic [3:0]  pd_be;
    pi_req = 1'b0;
    pd_req = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!pi_req) begin
        pi_req  = ($urandom_range(0, 2) != 0);
        pi_addr = rand_addr();
      end
      if (!pd_req) begin
        pd_req   = ($urandom_range(0, 1) != 0);
        pd_we    = ($urandom_range(0, 1) != 0);
        pd_be    = 4'($urandom);
        pd_addr  = rand_addr();
        pd_wdata = $urandom;
      end
      run_cycle(pi_req, pi_addr, pd_req, pd_we, pd_be, pd_addr, pd_wdata);
      if (obs_ig) pi_req = 1'b0;
      if (obs_dg) pd_req = 1'b0;
    end
    idle_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = init_word(i);
    model_reset();
    drive_idle();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_instr_stream();
    test_store_load();
    test_conflict();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
